// File: rtl/limdff_op_sequencer_if.sv
// Command handshake between a command source and the LiMDff op sequencer.
interface limdff_op_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_repeat;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_repeat, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/limdff_op_sequencer.sv
// Buffers opcode+operand commands in a small FIFO and issues each one to the
// LiMDff control lines for repeat+1 cycles, driving HOLD whenever nothing issues.
module limdff_op_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  limdff_op_sequencer_if.slave cmd,
  input  logic                 flush,
  input  logic                 stall,
  output logic                 do_force,
  output logic                 do_invert,
  output logic                 do_nand,
  output logic                 do_nxor,
  output logic [WIDTH-1:0]     lim_in,
  output logic                 op_fire,
  output logic                 op_done,
  output logic                 idle
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SET  = 3'd1,
    OP_NAND = 3'd2,
    OP_AND  = 3'd3,
    OP_NXOR = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] data;
    logic [3:0]       rep;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [3:0]      rep_cnt_q, rep_cnt_d;

  entry_t          head;
  state_e          state;
  logic            full;
  logic            empty;
  logic            ready;
  logic            push;
  logic            pop;

  // Issue mode is resolved each cycle from occupancy and the live stall/flush
  // inputs, so stall and flush take effect on the outputs in the same cycle.
  always_comb begin
    full  = (count_q == (AW + 1)'(DEPTH));
    empty = (count_q == '0);
    head  = mem_q[rd_ptr_q];

    if (rst || flush || empty) begin
      state = S_IDLE;
    end else if (stall) begin
      state = S_PAUSE;
    end else begin
      state = S_RUN;
    end

    ready = !full && !rst && !flush;
    push  = cmd.cmd_valid && ready;
    pop   = (state == S_RUN) && (rep_cnt_q == head.rep);
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rep_cnt_d = rep_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{op: op_e'(cmd.cmd_op), data: cmd.cmd_data, rep: cmd.cmd_repeat};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (state == S_RUN) begin
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 4'd1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rep_cnt_d = '0;
    end
  end

  always_comb begin
    do_force  = 1'b0;
    do_invert = 1'b1;
    do_nand   = 1'b0;
    do_nxor   = 1'b0;
    lim_in    = '0;
    op_fire   = 1'b0;
    op_done   = 1'b0;

    if (state == S_RUN) begin
      op_done = pop;
      op_fire = (head.op != OP_HOLD);
      if (head.op != OP_HOLD) begin
        lim_in = head.data;
      end
      case (head.op)
        OP_SET:  begin do_force = 1'b1; do_invert = 1'b0; end
        OP_NAND: begin do_nand  = 1'b1; do_invert = 1'b0; end
        OP_AND:  begin do_nand  = 1'b1; do_invert = 1'b1; end
        OP_NXOR: begin do_nxor  = 1'b1; do_invert = 1'b0; end
        OP_XOR:  begin do_nxor  = 1'b1; do_invert = 1'b1; end
        OP_NOR:  begin do_invert = 1'b0; end
        OP_OR:   begin do_invert = 1'b1; end
        default: begin do_invert = 1'b1; end
      endcase
    end

    idle          = rst || empty;
    cmd.cmd_ready = ready;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rep_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: tb/tb_limdff_op_sequencer.sv
// Scoreboard bench for limdff_op_sequencer with a behavioural LiMDff on its outputs.
module tb_limdff_op_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             stall = 1'b0;
  logic             do_force, do_invert, do_nand, do_nxor;
  logic [WIDTH-1:0] lim_in;
  logic             op_fire, op_done, idle;

  limdff_op_sequencer_if #(.WIDTH(WIDTH)) cmd_if ();

  limdff_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .flush     (flush),
    .stall     (stall),
    .do_force  (do_force),
    .do_invert (do_invert),
    .do_nand   (do_nand),
    .do_nxor   (do_nxor),
    .lim_in    (lim_in),
    .op_fire   (op_fire),
    .op_done   (op_done),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Behavioural LiMDff driven by the sequencer's control lines.
  logic [WIDTH-1:0] lim_out = '0;
  always @(posedge clk) begin
    logic [WIDTH-1:0] nxt;
    if (!rst) begin
      if (do_force)     nxt = lim_in;
      else if (do_nand) nxt = ~(lim_out & lim_in);
      else if (do_nxor) nxt = ~(lim_out ^ lim_in);
      else              nxt = ~(lim_out | lim_in);
      if (do_invert && !do_force) nxt = ~nxt;
      lim_out <= nxt;
    end
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic             last;
  } issue_t;

  issue_t           sb[$];
  int unsigned      tb_cnt   = 0;
  int unsigned      fire_cnt = 0;
  logic [WIDTH-1:0] exp_out  = '0;

  function automatic logic [3:0] enc(input logic [2:0] op);
    case (op)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0001;
      3'd5:    return 4'b0101;
      3'd6:    return 4'b0000;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] apply(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                             input logic [WIDTH-1:0] q);
    case (op)
      3'd1:    return d;
      3'd2:    return ~(q & d);
      3'd3:    return q & d;
      3'd4:    return ~(q ^ d);
      3'd5:    return q ^ d;
      3'd6:    return ~(q | d);
      3'd7:    return q | d;
      default: return q;
    endcase
  endfunction

  // Per-cycle reference: predict handshake, idle and issue, then account for
  // the push/flush/reset that takes effect at the coming edge.
  always @(negedge clk) begin
    logic   exp_ready;
    logic   exp_issue;
    issue_t it;
    exp_ready = !rst && !flush && (tb_cnt < DEPTH);
    exp_issue = !rst && !flush && !stall && (tb_cnt > 0);
    if (op_fire) fire_cnt++;
    check("cmd_ready", {31'd0, cmd_if.cmd_ready}, {31'd0, exp_ready});
    check("idle", {31'd0, idle}, {31'd0, rst || (tb_cnt == 0)});
    check("lim_out", {24'd0, lim_out}, {24'd0, exp_out});
    if (exp_issue) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        it = sb.pop_front();
        check("ctl", {28'd0, do_force, do_invert, do_nand, do_nxor}, {28'd0, enc(it.op)});
        check("lim_in", {24'd0, lim_in}, (it.op == 3'd0) ? 32'd0 : {24'd0, it.data});
        check("op_fire", {31'd0, op_fire}, {31'd0, it.op != 3'd0});
        check("op_done", {31'd0, op_done}, {31'd0, it.last});
        exp_out = apply(it.op, it.data, exp_out);
        if (it.last) tb_cnt--;
      end
    end else begin
      check("hold_ctl", {28'd0, do_force, do_invert, do_nand, do_nxor}, 32'b0100);
      check("hold_in", {24'd0, lim_in}, 32'd0);
      check("hold_fire", {31'd0, op_fire}, 32'd0);
      check("hold_done", {31'd0, op_done}, 32'd0);
    end
    if (rst || flush) begin
      sb.delete();
      tb_cnt = 0;
    end else if (cmd_if.cmd_valid && exp_ready) begin
      for (int unsigned r = 0; r <= cmd_if.cmd_repeat; r++) begin
        it.op   = cmd_if.cmd_op;
        it.data = cmd_if.cmd_data;
        it.last = (r == cmd_if.cmd_repeat);
        sb.push_back(it);
      end
      tb_cnt++;
    end
  end

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [3:0] rep);
    logic ok;
    ok = 1'b0;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_data   = data;
    cmd_if.cmd_repeat = rep;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (idle && tb_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned f0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_op     = '0;
    cmd_if.cmd_data   = '0;
    cmd_if.cmd_repeat = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: SET then XOR back to back
    f0 = fire_cnt;
    send(3'd1, 8'hA5, 4'd0);
    send(3'd5, 8'hFF, 4'd0);
    wait_idle();
    check("t1_fires", fire_cnt - f0, 32'd2);
    check("t1_out", {24'd0, lim_out}, 32'h5A);

    // 2: repeated XOR
    send(3'd1, 8'hA5, 4'd0);
    wait_idle();
    f0 = fire_cnt;
    send(3'd5, 8'h0F, 4'd2);
    wait_idle();
    check("t2_fires", fire_cnt - f0, 32'd3);
    check("t2_out", {24'd0, lim_out}, 32'hAA);

    // 3: fill FIFO under stall, fifth command held until a slot frees
    stall = 1'b1;
    f0 = fire_cnt;
    fork
      begin
        send(3'd5, 8'h01, 4'd0);
        send(3'd5, 8'h02, 4'd0);
        send(3'd5, 8'h04, 4'd0);
        send(3'd5, 8'h08, 4'd0);
        send(3'd5, 8'h10, 4'd0);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    wait_idle();
    check("t3_fires", fire_cnt - f0, 32'd5);
    check("t3_out", {24'd0, lim_out}, 32'hB5);

    // 4: AND with stall inserted mid-repeat
    f0 = fire_cnt;
    send(3'd3, 8'hF0, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_idle();
    check("t4_fires", fire_cnt - f0, 32'd4);
    check("t4_out", {24'd0, lim_out}, 32'hB0);

    // 5: flush with three queued entries and a concurrent offer
    stall = 1'b1;
    send(3'd1, 8'h11, 4'd0);
    send(3'd7, 8'h22, 4'd1);
    send(3'd6, 8'h33, 4'd0);
    flush = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd1;
    cmd_if.cmd_data  = 8'h44;
    @(posedge clk);
    #1;
    flush = 1'b0;
    stall = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("t5_idle", {31'd0, idle}, 32'd1);
    check("t5_out", {24'd0, lim_out}, 32'hB0);
    wait_idle();

    // 6: reset mid-repeat, then a fresh command repeats fully
    send(3'd7, 8'h01, 4'd5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_out", {24'd0, lim_out}, 32'hB1);
    f0 = fire_cnt;
    send(3'd1, 8'h3C, 4'd2);
    wait_idle();
    check("t6_fires", fire_cnt - f0, 32'd3);
    check("t6_out2", {24'd0, lim_out}, 32'h3C);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
